// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder.
//   opcode_t / funct3_t / csr_funct3_t : RV32I field encodings
//   imm_type_t                          : immediate format selected by opcode
//   IMM_*_MIN/MAX                       : signed range limits per format
//   li_split_t / li_split()             : LI pseudo-op split into LUI + ADDI
package instr_encoder_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'h03,
    OPCODE_OP_IMM = 7'h13,
    OPCODE_AUIPC  = 7'h17,
    OPCODE_STORE  = 7'h23,
    OPCODE_OP     = 7'h33,
    OPCODE_LUI    = 7'h37,
    OPCODE_BRANCH = 7'h63,
    OPCODE_JALR   = 7'h67,
    OPCODE_JAL    = 7'h6F,
    OPCODE_SYSTEM = 7'h73
  } opcode_t;

  typedef enum logic [2:0] {
    FUNCT3_ADD_SUB = 3'b000,
    FUNCT3_SLL     = 3'b001,
    FUNCT3_SLT     = 3'b010,
    FUNCT3_SLTU    = 3'b011,
    FUNCT3_XOR     = 3'b100,
    FUNCT3_SRL_SRA = 3'b101,
    FUNCT3_OR      = 3'b110,
    FUNCT3_AND     = 3'b111
  } funct3_t;

  typedef enum logic [2:0] {
    CSR_PRIV  = 3'b000,
    CSR_RW    = 3'b001,
    CSR_RS    = 3'b010,
    CSR_RC    = 3'b011,
    CSR_RWI   = 3'b101,
    CSR_RSI   = 3'b110,
    CSR_RCI   = 3'b111
  } csr_funct3_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_C
  } imm_type_t;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef struct packed {
    logic [19:0] hi;
    logic [11:0] lo;
    logic        two_word;
  } li_split_t;

  // Rounding hi by +0x800 makes the sign-extended lo land in [-2048, 2047];
  // the low 12 bits of (imm - hi<<12) are therefore just imm[11:0].
  function automatic li_split_t li_split(input logic [31:0] imm);
    li_split_t   r;
    logic [31:0] rounded;
    rounded    = imm + 32'h0000_0800;
    r.hi       = rounded[31:12];
    r.lo       = imm[11:0];
    r.two_word = !(($signed(imm) >= IMM_I_MIN) && ($signed(imm) <= IMM_I_MAX));
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational field packer: selects the immediate format from the opcode,
// scatters fields into an RV32I word and flags unrepresentable immediates.
//   opcode, funct3, funct7, rd, rs1, rs2, csr, imm : instruction fields
//   instr : packed instruction word
//   err   : immediate out of range / misaligned (fields truncated)
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] csr,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  imm_type_t          imm_type;
  logic signed [31:0] simm;

  assign simm = imm;

  always_comb begin
    imm_type = IMM_NONE;
    case (opcode)
      OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM: imm_type = IMM_I;
      OPCODE_STORE:                            imm_type = IMM_S;
      OPCODE_BRANCH:                           imm_type = IMM_B;
      OPCODE_LUI, OPCODE_AUIPC:                imm_type = IMM_U;
      OPCODE_JAL:                              imm_type = IMM_J;
      OPCODE_SYSTEM:                           imm_type = funct3[2] ? IMM_C : IMM_NONE;
      default:                                 imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    instr = {funct7, rs2, rs1, funct3, rd, opcode};
    err   = 1'b0;
    case (imm_type)
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
      end
      IMM_C: begin
        instr = {csr, imm[4:0], funct3, rd, opcode};
        err   = (imm[31:5] != 27'd0);
      end
      default: begin
        if (opcode == OPCODE_SYSTEM) begin
          instr = {csr, rs1, funct3, rd, opcode};
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs request fields into RV32I words with one
// registered output stage; LI pseudo-op expands to ADDI or LUI+ADDI.
//   clk, rst_n                : clock, async active-low reset
//   req_*                     : request fields, valid/ready handshake
//   out_valid/out_ready       : output handshake
//   out_instr/out_last/out_err: encoded word, final-word flag, range error
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned LI_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_imm,
  input  logic        req_li,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EMIT    = 2'd1;
  localparam logic [1:0] ST_EMIT_HI = 2'd2;

  logic [1:0]  state;
  logic [31:0] pend_instr;

  logic        accept;
  logic        li_eff;
  li_split_t   split;
  logic [31:0] pack_instr;
  logic        pack_err;

  logic [31:0] new_instr;
  logic        new_last;
  logic        new_err;
  logic        new_two;
  logic [31:0] new_pend;

  instr_field_pack u_pack (
    .opcode (req_opcode),
    .funct3 (req_funct3),
    .funct7 (req_funct7),
    .rd     (req_rd),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .csr    (req_csr),
    .imm    (req_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign req_ready = (state == ST_IDLE) || ((state == ST_EMIT) && out_ready);
  assign accept    = req_valid && req_ready;
  assign out_valid = (state != ST_IDLE);
  assign li_eff    = (LI_ENABLE != 0) && req_li;
  assign split     = li_split(req_imm);

  always_comb begin
    new_instr = pack_instr;
    new_last  = 1'b1;
    new_err   = pack_err;
    new_two   = 1'b0;
    new_pend  = '0;
    if (li_eff) begin
      new_err = 1'b0;
      if (split.two_word) begin
        new_instr = {split.hi, req_rd, OPCODE_LUI};
        new_last  = 1'b0;
        new_two   = 1'b1;
        new_pend  = {split.lo, req_rd, FUNCT3_ADD_SUB, req_rd, OPCODE_OP_IMM};
      end else begin
        new_instr = {split.lo, 5'd0, FUNCT3_ADD_SUB, req_rd, OPCODE_OP_IMM};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_instr  <= '0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      pend_instr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_EMIT: begin
          if (accept) begin
            out_instr  <= new_instr;
            out_last   <= new_last;
            out_err    <= new_err;
            pend_instr <= new_pend;
            state      <= new_two ? ST_EMIT_HI : ST_EMIT;
          end else if ((state == ST_EMIT) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_EMIT_HI: begin
          if (out_ready) begin
            out_instr <= pend_instr;
            out_last  <= 1'b1;
            out_err   <= 1'b0;
            state     <= ST_EMIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vector table, hand-written stall and
// reset sequences, and randomized requests against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [11:0] req_csr;
  logic [31:0] req_imm;
  logic        req_li;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.LI_ENABLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_csr    (req_csr),
    .req_imm    (req_imm),
    .req_li     (req_li),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .out_err    (out_err)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] csr;
    logic [31:0] imm;
    logic        li;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [31:0] imm12);
    return ((imm12 & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction

  // Reference: works from numeric ranges and shift/mask arithmetic on the value.
  function automatic void model(input vec_t v, output logic [31:0] w0, output logic [31:0] w1,
                                output int n, output logic err);
    longint      s;
    logic [31:0] x, hi, lo, base;
    s  = longint'($signed(v.imm));
    x  = v.imm;
    w1 = '0;
    n  = 1;
    err = 1'b0;
    if (v.li) begin
      if (s >= -2048 && s <= 2047) begin
        w0 = enc_addi(v.rd, 5'd0, x);
      end else begin
        hi = ((x + 32'h800) >> 12) & 32'hFFFFF;
        lo = x - (hi << 12);
        w0 = (hi << 12) | (32'(v.rd) << 7) | 32'h37;
        w1 = enc_addi(v.rd, v.rd, lo);
        n  = 2;
      end
      return;
    end
    base = (32'(v.rs1) << 15) | (32'(v.f3) << 12) | 32'(v.op);
    case (v.op)
      7'h03, 7'h13, 7'h67: begin
        w0  = ((x & 32'hFFF) << 20) | base | (32'(v.rd) << 7);
        err = (s < -2048 || s > 2047);
      end
      7'h23: begin
        w0  = (((x >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | base | ((x & 32'h1F) << 7);
        err = (s < -2048 || s > 2047);
      end
      7'h63: begin
        w0  = (((x >> 12) & 1) << 31) | (((x >> 5) & 32'h3F) << 25) | (32'(v.rs2) << 20) | base
            | (((x >> 1) & 32'hF) << 8) | (((x >> 11) & 1) << 7);
        err = (s < -4096 || s > 4094 || (x % 2) != 0);
      end
      7'h37, 7'h17: begin
        w0  = (x & 32'hFFFFF000) | (32'(v.rd) << 7) | 32'(v.op);
        err = (x % 4096) != 0;
      end
      7'h6F: begin
        w0  = (((x >> 20) & 1) << 31) | (((x >> 1) & 32'h3FF) << 21) | (((x >> 11) & 1) << 20)
            | (((x >> 12) & 32'hFF) << 12) | (32'(v.rd) << 7) | 32'h6F;
        err = (s < -1048576 || s > 1048574 || (x % 2) != 0);
      end
      7'h73: begin
        if (v.f3 >= 3'd4) begin
          w0  = (32'(v.csr) << 20) | ((x & 32'h1F) << 15) | (32'(v.f3) << 12) | (32'(v.rd) << 7) | 32'h73;
          err = x > 32'd31;
        end else begin
          w0 = (32'(v.csr) << 20) | base | (32'(v.rd) << 7);
        end
      end
      default: w0 = (32'(v.f7) << 25) | (32'(v.rs2) << 20) | base | (32'(v.rd) << 7);
    endcase
  endfunction

  task automatic drive(input vec_t v);
    req_opcode = v.op;  req_funct3 = v.f3;  req_funct7 = v.f7;
    req_rd = v.rd;      req_rs1 = v.rs1;    req_rs2 = v.rs2;
    req_csr = v.csr;    req_imm = v.imm;    req_li = v.li;
    req_valid = 1'b1;
  endtask

  // One request with out_ready held high; checks every emitted word.
  task automatic send(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #1 chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".valid0"}, 32'(out_valid), 32'd1);
    chk({nm, ".w0"}, out_instr, v.w0);
    chk({nm, ".err"}, 32'(out_err), 32'(v.err));
    chk({nm, ".last0"}, 32'(out_last), (v.n == 1) ? 32'd1 : 32'd0);
    if (v.n == 2) begin
      chk({nm, ".ready_hi"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      chk({nm, ".valid1"}, 32'(out_valid), 32'd1);
      chk({nm, ".w1"}, out_instr, v.w1);
      chk({nm, ".last1"}, 32'(out_last), 32'd1);
      chk({nm, ".err1"}, 32'(out_err), 32'd0);
    end
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [11:0] csr, input logic [31:0] imm, input logic li,
                              input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic err);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.csr = csr; v.imm = imm; v.li = li; v.n = n; v.w0 = w0; v.w1 = w1; v.err = err;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [6:0] ops[10];
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0; req_rd = '0; req_rs1 = '0;
    req_rs2 = '0; req_csr = '0; req_imm = '0; req_li = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.err", 32'(out_err), 32'd0);
    rst_n = 1'b1;

    vecs.push_back(mk(7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 12'd0, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFF10093, 0, 1'b0));
    vecs.push_back(mk(7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 12'd0, 32'd8,        1'b0, 1, 32'h00512423, 0, 1'b0));
    vecs.push_back(mk(7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 12'd0, 32'd2048,     1'b0, 1, 32'h80512023, 0, 1'b1));
    vecs.push_back(mk(7'h00, 3'd0, 7'd0, 5'd5, 5'd9, 5'd9, 12'd0, 32'h12345678, 1'b1, 2, 32'h123452B7, 32'h67828293, 1'b0));
    vecs.push_back(mk(7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd0, 32'h7FFFF800, 1'b1, 2, 32'h800000B7, 32'h80008093, 1'b0));
    vecs.push_back(mk(7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd0, 32'hFFFFF800, 1'b1, 1, 32'h80000093, 0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 12'd0, 32'd3,        1'b0, 1, 32'h00208163, 0, 1'b1));
    vecs.push_back(mk(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0, 32'hFFFFF000, 1'b0, 1, 32'h80000063, 0, 1'b0));
    vecs.push_back(mk(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0, 32'hFFFFEFFE, 1'b0, 1, 32'h7E000FE3, 0, 1'b1));
    vecs.push_back(mk(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd0, 32'd8,        1'b0, 1, 32'h008000EF, 0, 1'b0));
    vecs.push_back(mk(7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 12'd0, 32'h12345000, 1'b0, 1, 32'h123451B7, 0, 1'b0));
    vecs.push_back(mk(7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 12'd0, 32'h12345001, 1'b0, 1, 32'h123451B7, 0, 1'b1));
    vecs.push_back(mk(7'h73, 3'd5, 7'd0, 5'd0, 5'd0, 5'd0, 12'h300, 32'd5,      1'b0, 1, 32'h3002D073, 0, 1'b0));
    vecs.push_back(mk(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 12'd0, 32'd0,       1'b0, 1, 32'h403100B3, 0, 1'b0));

    foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));

    // Stall: branch word held while out_ready=0, then back-to-back follow-on.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[6]);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.instr", out_instr, 32'h00208163);
      chk("hold.last", 32'(out_last), 32'd1);
      chk("hold.err", 32'(out_err), 32'd1);
      chk("hold.ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[0]);
    #1 chk("b2b.ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.valid", 32'(out_valid), 32'd1);
    chk("b2b.instr", out_instr, 32'hFFF10093);

    // Async reset while the LUI is presented discards the pending ADDI.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[3]);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rsthi.lui", out_instr, 32'h123452B7);
    rst_n = 1'b0;
    #1 chk("rsthi.valid", 32'(out_valid), 32'd0);
    chk("rsthi.instr", out_instr, 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rsthi.idle", 32'(out_valid), 32'd0);
    end
    send(vecs[1], "post_rst");

    for (int k = 0; k < 200; k++) begin
      v.op  = ops[$urandom_range(0, 9)];
      v.f3  = 3'($urandom);
      v.f7  = 7'($urandom);
      v.rd  = 5'($urandom);
      v.rs1 = 5'($urandom);
      v.rs2 = 5'($urandom);
      v.csr = 12'($urandom);
      case ($urandom_range(0, 3))
        0: v.imm = $urandom;
        1: v.imm = 32'($urandom_range(0, 8192)) - 32'd4096;
        2: v.imm = $urandom & 32'hFFFFF000;
        default: v.imm = 32'($urandom_range(0, 40));
      endcase
      v.li = ($urandom_range(0, 3) == 0);
      model(v, v.w0, v.w1, v.n, v.err);
      send(v, $sformatf("rnd%0d", k));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
